// File: rtl/merge_2.sv
// Two-input round-robin merge into a 2-entry output FIFO tagged with source.
// Optional packet lock (hold grant until tail flit) enabled by MERGE_2_PKT_LOCK_EN.
module merge_2 #(
  parameter int W        = 11,
  parameter int TAIL_BIT = 10
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] inPort1_data,
  input  logic         inPort1_valid,
  output logic         inPort1_ready,
  input  logic [W-1:0] inPort2_data,
  input  logic         inPort2_valid,
  output logic         inPort2_ready,
  output logic [W-1:0] outPort_data,
  output logic         outPort_valid,
  input  logic         outPort_ready,
  output logic         outPort_src
);

  logic [W:0]   r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         r_last_grant;
  logic [W-1:0] r_hold_data;
  logic         r_hold_src;

  logic         w_space;
  logic         w_rr_v;
  logic         w_rr_src;
  logic         w_gnt_v;
  logic         w_gnt_src;
  logic         w_push;
  logic         w_pop;
  logic [W-1:0] w_in_data;

  assign w_space = (r_count < 2'd2);

  // r_last_grant uses the src encoding (1 = input 2), so reset value 1 favours input 1
  always_comb begin
    w_rr_v   = 1'b0;
    w_rr_src = 1'b0;
    if (inPort1_valid && inPort2_valid) begin
      w_rr_v   = 1'b1;
      w_rr_src = ~r_last_grant;
    end else if (inPort1_valid) begin
      w_rr_v   = 1'b1;
      w_rr_src = 1'b0;
    end else if (inPort2_valid) begin
      w_rr_v   = 1'b1;
      w_rr_src = 1'b1;
    end
  end

`ifdef MERGE_2_PKT_LOCK_EN
  typedef enum logic [1:0] {LK_NONE, LK_IN1, LK_IN2} lock_t;
  lock_t r_lock;
  lock_t w_lock_nxt;

  always_comb begin
    w_gnt_v   = 1'b0;
    w_gnt_src = 1'b0;
    if (w_space) begin
      case (r_lock)
        LK_IN1:  begin w_gnt_v = inPort1_valid; w_gnt_src = 1'b0; end
        LK_IN2:  begin w_gnt_v = inPort2_valid; w_gnt_src = 1'b1; end
        default: begin w_gnt_v = w_rr_v;        w_gnt_src = w_rr_src; end
      endcase
    end
  end

  always_comb begin
    w_lock_nxt = r_lock;
    if (w_push) begin
      if (r_lock == LK_NONE) begin
        if (!w_in_data[TAIL_BIT]) w_lock_nxt = w_gnt_src ? LK_IN2 : LK_IN1;
      end else if (w_in_data[TAIL_BIT]) begin
        w_lock_nxt = LK_NONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) r_lock <= LK_NONE;
    else         r_lock <= w_lock_nxt;
  end
`else
  logic w_unused_tail;
  assign w_unused_tail = w_in_data[TAIL_BIT];

  always_comb begin
    w_gnt_v   = w_space & w_rr_v;
    w_gnt_src = w_rr_src;
  end
`endif

  assign w_in_data     = w_gnt_src ? inPort2_data : inPort1_data;
  assign inPort1_ready = _RESET & w_gnt_v & ~w_gnt_src;
  assign inPort2_ready = _RESET & w_gnt_v &  w_gnt_src;
  assign w_push        = w_gnt_v;
  assign w_pop         = (r_count != 2'd0) & outPort_ready;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_mem[0]     <= '0;
      r_mem[1]     <= '0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
      r_hold_data  <= '0;
      r_hold_src   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_gnt_src, w_in_data};
        r_wptr        <= ~r_wptr;
        r_last_grant  <= w_gnt_src;
      end
      if (w_pop) begin
        r_rptr      <= ~r_rptr;
        r_hold_data <= r_mem[r_rptr][W-1:0];
        r_hold_src  <= r_mem[r_rptr][W];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Once drained, present the last popped flit rather than a stale slot
  assign outPort_valid = (r_count != 2'd0);
  assign outPort_data  = outPort_valid ? r_mem[r_rptr][W-1:0] : r_hold_data;
  assign outPort_src   = outPort_valid ? r_mem[r_rptr][W]     : r_hold_src;

endmodule

// File: tb/tb_merge_2.sv
// Scoreboard bench for merge_2: expected {src,data} queued at drive time, checked on output.
module tb_merge_2;
  logic        CLK = 1'b0;
  logic        _RESET = 1'b1;
  logic [10:0] in1_d = '0, in2_d = '0, out_d;
  logic        v1 = 1'b0, v2 = 1'b0, ordy = 1'b0;
  logic        r1, r2, ov, osrc;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] sb[$];
  logic [11:0] exp_f;

`ifdef MERGE_2_PKT_LOCK_EN
  localparam logic [10:0] TF = 11'h400;
`else
  localparam logic [10:0] TF = 11'h000;
`endif

  merge_2 #(.W(11), .TAIL_BIT(10)) dut (
    .CLK(CLK), ._RESET(_RESET),
    .inPort1_data(in1_d), .inPort1_valid(v1), .inPort1_ready(r1),
    .inPort2_data(in2_d), .inPort2_valid(v2), .inPort2_ready(r2),
    .outPort_data(out_d), .outPort_valid(ov), .outPort_ready(ordy),
    .outPort_src(osrc)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    _RESET = 1'b0;
    v1 = 1'b0; v2 = 1'b0;
    tick();
    _RESET = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    v1 = 1'b1; v2 = 1'b1; ordy = 1'b1;
    in1_d = 11'h3AA; in2_d = 11'h1BB;
    #2 _RESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if ({r1, r2, ov} !== 3'b000) begin
        errors++; $display("FAIL reset_hold: r1r2valid=%b want 000", {r1, r2, ov});
      end
    end
    checks++;
    if ({osrc, out_d} !== 12'h000) begin
      errors++; $display("FAIL reset_out: got %h want 000", {osrc, out_d});
    end
    tick();
    _RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if ({r1, r2} !== 2'b10) begin
      errors++; $display("FAIL reset_first_grant: r1r2=%b want 10", {r1, r2});
    end
    sb.push_back({1'b0, in1_d});
    tick();
    v1 = 1'b0; v2 = 1'b0;
    @(negedge CLK);
    checks++;
    if (ov !== 1'b1) begin
      errors++; $display("FAIL reset_first_valid: got %b want 1", ov);
    end else begin
      exp_f = sb.pop_front();
      checks++;
      if ({osrc, out_d} !== exp_f) begin
        errors++; $display("FAIL reset_first_data: got %h want %h", {osrc, out_d}, exp_f);
      end
    end
    tick();
  endtask

  task automatic test_single();
    pulse_reset();
    ordy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      v1 = (c < 8); v2 = 1'b0;
      in1_d = 11'(c + 1);
      @(negedge CLK);
      checks++;
      if (ov !== (sb.size() != 0)) begin
        errors++; $display("FAIL single_valid c%0d: got %b want %b", c, ov, sb.size() != 0);
      end else if (ov) begin
        exp_f = sb.pop_front();
        checks++;
        if ({osrc, out_d} !== exp_f) begin
          errors++; $display("FAIL single_data c%0d: got %h want %h", c, {osrc, out_d}, exp_f);
        end
      end
      checks++;
      if (r1 !== (c < 8)) begin
        errors++; $display("FAIL single_ready c%0d: got %b want %b", c, r1, c < 8);
      end
      if (c < 8) sb.push_back({1'b0, in1_d});
      tick();
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    ordy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      v1 = (c < 8); v2 = (c < 8);
      in1_d = TF | (11'h100 + 11'((c + 1) / 2));
      in2_d = TF | (11'h200 + 11'(c / 2));
      @(negedge CLK);
      checks++;
      if (ov !== (sb.size() != 0)) begin
        errors++; $display("FAIL cont_valid c%0d: got %b want %b", c, ov, sb.size() != 0);
      end else if (ov) begin
        exp_f = sb.pop_front();
        checks++;
        if ({osrc, out_d} !== exp_f) begin
          errors++; $display("FAIL cont_data c%0d: got %h want %h", c, {osrc, out_d}, exp_f);
        end
      end
      if (c < 8) begin
        checks++;
        if ({r1, r2} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL cont_grant c%0d: r1r2=%b want %b", c, {r1, r2},
                             (c % 2 == 0) ? 2'b10 : 2'b01);
        end
        if (c % 2 == 0) sb.push_back({1'b0, in1_d});
        else            sb.push_back({1'b1, in2_d});
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit exp_r2[8] = '{1, 1, 0, 0, 0, 1, 0, 0};
    int n = 0;
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      ordy = (c >= 4);
      v1 = 1'b0; v2 = (n < 3);
      in2_d = 11'h055 + 11'(n);
      @(negedge CLK);
      checks++;
      if (ov !== (sb.size() != 0)) begin
        errors++; $display("FAIL bp_valid c%0d: got %b want %b", c, ov, sb.size() != 0);
      end else if (ov) begin
        exp_f = ordy ? sb.pop_front() : sb[0];
        checks++;
        if ({osrc, out_d} !== exp_f) begin
          errors++; $display("FAIL bp_data c%0d: got %h want %h", c, {osrc, out_d}, exp_f);
        end
      end
      checks++;
      if (r2 !== exp_r2[c]) begin
        errors++; $display("FAIL bp_ready c%0d: got %b want %b", c, r2, exp_r2[c]);
      end
      if (exp_r2[c]) begin
        sb.push_back({1'b1, in2_d});
        n++;
      end
      tick();
    end
    @(negedge CLK);
    checks++;
    if ({ov, osrc, out_d} !== {1'b0, 1'b1, 11'h057}) begin
      errors++; $display("FAIL bp_hold: got %h want %h", {ov, osrc, out_d}, {1'b0, 1'b1, 11'h057});
    end
    tick();
  endtask

  task automatic test_push_pop();
    pulse_reset();
    for (int c = 0; c < 5; c++) begin
      ordy = (c >= 1);
      v1 = (c < 3); v2 = 1'b0;
      in1_d = 11'h0A1 + 11'(c);
      @(negedge CLK);
      checks++;
      if (ov !== (sb.size() != 0)) begin
        errors++; $display("FAIL pp_valid c%0d: got %b want %b", c, ov, sb.size() != 0);
      end else if (ov) begin
        exp_f = sb.pop_front();
        checks++;
        if ({osrc, out_d} !== exp_f) begin
          errors++; $display("FAIL pp_data c%0d: got %h want %h", c, {osrc, out_d}, exp_f);
        end
      end
      checks++;
      if (r1 !== (c < 3)) begin
        errors++; $display("FAIL pp_ready c%0d: got %b want %b", c, r1, c < 3);
      end
      if (c < 3) sb.push_back({1'b0, in1_d});
      tick();
    end
  endtask

  task automatic test_packet();
`ifdef MERGE_2_PKT_LOCK_EN
    bit          t_v1[6] = '{1, 0, 1, 1, 0, 0};
    logic [10:0] t_d1[6] = '{11'h101, 11'h000, 11'h102, 11'h503, 11'h000, 11'h000};
    bit          t_r1[6] = '{1, 0, 1, 1, 0, 0};
    bit          t_r2[6] = '{0, 0, 0, 0, 1, 1};
`else
    bit          t_v1[6] = '{1, 0, 1, 1, 1, 0};
    logic [10:0] t_d1[6] = '{11'h101, 11'h000, 11'h102, 11'h503, 11'h503, 11'h000};
    bit          t_r1[6] = '{1, 0, 1, 0, 1, 0};
    bit          t_r2[6] = '{0, 1, 0, 1, 0, 1};
`endif
    int n2 = 0;
    pulse_reset();
    ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      v1 = (c < 6) ? t_v1[c] : 1'b0;
      in1_d = (c < 6) ? t_d1[c] : 11'h000;
      v2 = (c < 6);
      in2_d = 11'h600 + 11'(n2);
      @(negedge CLK);
      checks++;
      if (ov !== (sb.size() != 0)) begin
        errors++; $display("FAIL pkt_valid c%0d: got %b want %b", c, ov, sb.size() != 0);
      end else if (ov) begin
        exp_f = sb.pop_front();
        checks++;
        if ({osrc, out_d} !== exp_f) begin
          errors++; $display("FAIL pkt_data c%0d: got %h want %h", c, {osrc, out_d}, exp_f);
        end
      end
      if (c < 6) begin
        checks++;
        if ({r1, r2} !== {t_r1[c], t_r2[c]}) begin
          errors++; $display("FAIL pkt_grant c%0d: r1r2=%b want %b", c, {r1, r2}, {t_r1[c], t_r2[c]});
        end
        if (t_r1[c]) sb.push_back({1'b0, in1_d});
        if (t_r2[c]) begin
          sb.push_back({1'b1, in2_d});
          n2++;
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_push_pop();
    test_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/merge_2.md
Name: merge_2

Overview:
- Clocked two-input merge stage that sits directly downstream of split_2 in the router datapath.
- Takes 11-bit flits from two independent valid/ready channels, for example outPort1 of one split_2 and outPort2 of another.
- Arbitrates round-robin between them and emits a single merged flit stream through a 2-entry output FIFO.
- Used as the RTL counterpart of the CSP merge gold model in cosim.

Parameters:
- W, 11, flit width in bits; applies to both inputs and the output.
- TAIL_BIT, 10, bit index marking the last flit of a packet; used only when MERGE_2_PKT_LOCK_EN is defined.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- _RESET  input  1  asynchronous, active-low reset.
- inPort1_data  input  W  flit on input 1.
- inPort1_valid  input  1  input 1 flit present.
- inPort1_ready  output  1  input 1 accepted this cycle when valid and ready are both high.
- inPort2_data  input  W  flit on input 2.
- inPort2_valid  input  1  input 2 flit present.
- inPort2_ready  output  1  input 2 accepted this cycle when valid and ready are both high.
- outPort_data  output  W  head-of-FIFO flit.
- outPort_valid  output  1  FIFO not empty.
- outPort_ready  input  1  consumer takes the flit this cycle.
- outPort_src  output  1  source of the head flit: 0 = input 1, 1 = input 2.

Behaviour:
- Reset (_RESET low, asynchronous):
  - FIFO count = 0 and read/write pointers = 0.
  - outPort_valid = 0, outPort_data = 0, outPort_src = 0.
  - last_grant = 1, so input 1 wins the first contention.
  - inPort1_ready = inPort2_ready = 0 while reset is asserted.
  - Reset mid-transfer discards all buffered flits.
- space = (count < 2). The ready signals depend only on registered state, never combinationally on outPort_ready.
- Grant each cycle when space = 1:
  - Only input 1 valid -> grant 1.
  - Only input 2 valid -> grant 2.
  - Both valid -> grant the input not equal to last_grant.
  - Neither valid -> no grant.
- inPortX_ready = space AND (grant == X). The non-granted input sees ready = 0.
- On an accepted flit:
  - Write {src, data} at the write pointer.
  - Update last_grant to the granted input.
  - Advance the write pointer, modulo 2.
- Pop when outPort_valid AND outPort_ready; advance the read pointer, modulo 2.
- Count update: push only -> +1; pop only -> -1; push and pop in the same cycle -> unchanged.
- Full (count = 2): no push, even if a pop occurs that cycle. This costs one bubble and is accepted.
- Empty: outPort_valid = 0; outPort_data and outPort_src hold their last value. The checker ignores them when outPort_valid is low.
- Latency: a flit accepted at edge N appears on outPort with outPort_valid = 1 after edge N, i.e. in cycle N+1.
- Throughput: one flit per cycle while count < 2 and the consumer drains every cycle.
- Ordering: per-input FIFO order is preserved; no flit is dropped or duplicated.
- Data path: pure pass-through, no arithmetic; width W on both inputs and the output.

Optional Feature:
- Macro: MERGE_2_PKT_LOCK_EN.
- Defined:
  - After an input is granted a flit with data[TAIL_BIT] = 0, the merge locks to that input.
  - While locked, the other input gets ready = 0 even if valid.
  - The lock releases after the accepted flit with data[TAIL_BIT] = 1.
  - A single-flit packet (tail set on the first flit) never locks.
  - The lock register resets to unlocked.
  - While locked and the owner is not valid, no grant is made and the other input keeps waiting.
- Not defined: flit-level round-robin as described above; TAIL_BIT is ignored.

Test Plan:
- Reset check: hold _RESET = 0 for 4 cycles with both inputs valid -> both readies = 0, outPort_valid = 0, no flits emitted. Release reset -> first accept comes from input 1.
- Single source: input 1 sends 0x001..0x008 back-to-back, outPort_ready = 1 -> output is 0x001..0x008 in order, outPort_src = 0, one cycle latency, one flit per cycle.
- Contention: both inputs always valid (in1 = 0x100+i, in2 = 0x200+i), outPort_ready = 1 -> output alternates 0x100, 0x200, 0x101, 0x201, …
- Backpressure: outPort_ready = 0, input 2 sends 0x055, 0x056, 0x057 -> only two are accepted and inPort2_ready drops. Raise outPort_ready -> 0x055, 0x056, 0x057 emerge, nothing lost.
- Simultaneous push/pop at count = 1 -> count stays 1; output order stays intact.
- MERGE_2_PKT_LOCK_EN: in1 sends a 3-flit packet (tail on the third) while in2 is continuously valid -> all 3 in1 flits are emitted contiguously before any in2 flit. Without the macro they interleave.
